fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the main/ALU decoders. It owns the PC and issues word requests to instruction memory over a req/ack handshake. It holds each fetched instruction stable with a valid flag until decode accepts it, then takes the next PC from the accept-cycle redirect inputs: sequential, taken branch, or jump. It drives op/funct to the decoders and pcplus4 to the branch-target adder.

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory req/ack plus the decode-side hold/accept handshake.
// master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic        instr_ready;
    logic        pcsrc;
    logic        jump;
    logic [31:0] pcbranch;
    logic [31:0] pcplus4;
    logic        fetch_err;
    logic [31:0] instr_count;

    modport master (
        output imem_req, imem_addr, instr, op, funct, instr_valid, pcplus4, fetch_err, instr_count,
        input  imem_ack, imem_rdata, instr_ready, pcsrc, jump, pcbranch
    );

    modport slave (
        input  imem_req, imem_addr, instr, op, funct, instr_valid, pcplus4, fetch_err, instr_count,
        output imem_ack, imem_rdata, instr_ready, pcsrc, jump, pcbranch
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word per req/ack, holds it for decode.
// Latency: ack to instr_valid is 1 cycle; at most one instruction per 2 cycles.
// Backpressure: instr_ready low holds the instruction (and PC) indefinitely; no new request issued.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam logic [0:0]  FETCH = 1'b0;
    localparam logic [0:0]  HOLD  = 1'b1;
    localparam logic [15:0] TMO   = 16'(TIMEOUT);

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        err_q;
    logic [15:0] wait_cnt;
    logic [31:0] pcplus4;
    logic [31:0] next_pc;

    assign pcplus4 = pc + 32'd4;

    // Redirect priority: jump over taken branch over sequential.
    always_comb begin
        next_pc = pcplus4;
        if (bus.jump)
            next_pc = {pcplus4[31:28], instr_q[25:0], 2'b00};
        else if (bus.pcsrc)
            next_pc = {bus.pcbranch[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= {RESET_PC[31:2], 2'b00};
            instr_q  <= 32'd0;
            count_q  <= 32'd0;
            err_q    <= 1'b0;
            wait_cnt <= 16'd0;
        end else if (state == FETCH) begin
            if (bus.imem_ack) begin
                instr_q  <= bus.imem_rdata;
                state    <= HOLD;
                wait_cnt <= 16'd0;
            end else begin
                if (wait_cnt != TMO)
                    wait_cnt <= wait_cnt + 16'd1;
                // Sticky: set on the edge where the count reaches TMO, held until reset.
                if (wait_cnt >= TMO - 16'd1)
                    err_q <= 1'b1;
            end
        end else begin
            if (bus.instr_ready) begin
                pc       <= next_pc;
                count_q  <= count_q + 32'd1;
                state    <= FETCH;
                wait_cnt <= 16'd0;
            end
        end
    end

    // Request is gated by reset so nothing is issued while the PC is being reloaded.
    assign bus.imem_req    = (state == FETCH) && !reset;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[31:26];
    assign bus.funct       = instr_q[5:0];
    assign bus.instr_valid = (state == HOLD);
    assign bus.pcplus4     = pcplus4;
    assign bus.fetch_err   = err_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: acked words are queued, then compared when decode sees them.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h00000000;
    localparam int          TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if fi();

    fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fi)
    );

    logic [31:0] sb[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] exp_i;
    int n_cmp = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_with(input logic [31:0] d);
        fi.imem_ack = 1'b1;
        fi.imem_rdata = d;
        sb.push_back(d);
        tick();
        fi.imem_ack = 1'b0;
        fi.imem_rdata = 32'd0;
    endtask

    // Handshake with decode; the bench's own PC model picks the next address.
    task automatic accept(input logic ps, input logic jp, input logic [31:0] br, input logic [31:0] ins);
        logic [31:0] p4;
        p4 = exp_pc + 32'd4;
        fi.instr_ready = 1'b1;
        fi.pcsrc = ps;
        fi.jump = jp;
        fi.pcbranch = br;
        tick();
        fi.instr_ready = 1'b0;
        fi.pcsrc = 1'b0;
        fi.jump = 1'b0;
        fi.pcbranch = 32'd0;
        if (jp)
            exp_pc = {p4[31:28], ins[25:0], 2'b00};
        else if (ps)
            exp_pc = {br[31:2], 2'b00};
        else
            exp_pc = p4;
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (fi.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", fi.imem_req); end
        n_cmp++; if (fi.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", fi.instr_valid); end
        n_cmp++; if (fi.instr !== 32'd0) begin n_err++; $display("FAIL reset_instr: got %h want 0", fi.instr); end
        n_cmp++; if (fi.instr_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fi.instr_count); end
        n_cmp++; if (fi.fetch_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", fi.fetch_err); end
        n_cmp++; if (fi.imem_addr !== RPC) begin n_err++; $display("FAIL reset_addr: got %h want %h", fi.imem_addr, RPC); end
        reset = 1'b0;
        exp_pc = RPC;
        exp_cnt = 32'd0;
        #1;
        n_cmp++; if (fi.imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", fi.imem_req); end
    endtask

    task automatic test_zero_wait();
        n_cmp++; if (fi.imem_addr !== exp_pc) begin n_err++; $display("FAIL zw_addr: got %h want %h", fi.imem_addr, exp_pc); end
        ack_with(32'h20080005);
        exp_i = sb.pop_front();
        n_cmp++; if (fi.instr_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid: got %b want 1", fi.instr_valid); end
        n_cmp++; if (fi.instr !== exp_i) begin n_err++; $display("FAIL zw_instr: got %h want %h", fi.instr, exp_i); end
        n_cmp++; if (fi.op !== 6'b001000) begin n_err++; $display("FAIL zw_op: got %b want 001000", fi.op); end
        n_cmp++; if (fi.imem_req !== 1'b0) begin n_err++; $display("FAIL zw_req_hold: got %b want 0", fi.imem_req); end
        n_cmp++; if (fi.pcplus4 !== exp_pc + 32'd4) begin n_err++; $display("FAIL zw_pcplus4: got %h want %h", fi.pcplus4, exp_pc + 32'd4); end
        accept(1'b0, 1'b0, 32'd0, exp_i);
        n_cmp++; if (fi.imem_addr !== 32'h4) begin n_err++; $display("FAIL zw_next_addr: got %h want 00000004", fi.imem_addr); end
        n_cmp++; if (fi.instr_count !== exp_cnt) begin n_err++; $display("FAIL zw_count: got %0d want %0d", fi.instr_count, exp_cnt); end
        n_cmp++; if (fi.instr_valid !== 1'b0) begin n_err++; $display("FAIL zw_valid_drop: got %b want 0", fi.instr_valid); end
    endtask

    task automatic test_delayed_ack();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (fi.imem_addr !== exp_pc || fi.imem_req !== 1'b1) begin n_err++; $display("FAIL dly_addr%0d: got %h/%b want %h/1", i, fi.imem_addr, fi.imem_req, exp_pc); end
            n_cmp++; if (fi.instr_valid !== 1'b0) begin n_err++; $display("FAIL dly_valid%0d: got %b want 0", i, fi.instr_valid); end
        end
        ack_with(32'h012A4020);
        exp_i = sb.pop_front();
        n_cmp++; if (fi.instr_valid !== 1'b1) begin n_err++; $display("FAIL dly_valid_rise: got %b want 1", fi.instr_valid); end
        n_cmp++; if (fi.instr !== exp_i) begin n_err++; $display("FAIL dly_instr: got %h want %h", fi.instr, exp_i); end
        n_cmp++; if (fi.funct !== 6'h20) begin n_err++; $display("FAIL dly_funct: got %h want 20", fi.funct); end
        n_cmp++; if (fi.fetch_err !== 1'b0) begin n_err++; $display("FAIL dly_err: got %b want 0", fi.fetch_err); end
        accept(1'b0, 1'b0, 32'd0, exp_i);
    endtask

    task automatic test_hold_stall();
        ack_with(32'h8D2A0008);
        exp_i = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            fi.pcsrc = i[0];
            fi.jump = ~i[0];
            fi.pcbranch = $urandom();
            if (i == 2) begin
                fi.imem_ack = 1'b1;
                fi.imem_rdata = 32'hDEADBEEF;
            end
            tick();
            fi.imem_ack = 1'b0;
            fi.imem_rdata = 32'd0;
            n_cmp++; if (fi.instr !== exp_i) begin n_err++; $display("FAIL hold_instr%0d: got %h want %h", i, fi.instr, exp_i); end
            n_cmp++; if (fi.imem_req !== 1'b0 || fi.instr_valid !== 1'b1) begin n_err++; $display("FAIL hold_hs%0d: got req %b vld %b want 0/1", i, fi.imem_req, fi.instr_valid); end
            n_cmp++; if (fi.imem_addr !== exp_pc) begin n_err++; $display("FAIL hold_pc%0d: got %h want %h", i, fi.imem_addr, exp_pc); end
        end
        fi.pcsrc = 1'b0;
        fi.jump = 1'b0;
        fi.pcbranch = 32'd0;
        n_cmp++; if (fi.op !== 6'h23) begin n_err++; $display("FAIL hold_op: got %h want 23", fi.op); end
        accept(1'b0, 1'b0, 32'd0, exp_i);
    endtask

    task automatic test_redirect();
        ack_with(32'h00000000);
        exp_i = sb.pop_front();
        accept(1'b0, 1'b0, 32'd0, exp_i);
        n_cmp++; if (fi.imem_addr !== 32'h10) begin n_err++; $display("FAIL br_start: got %h want 00000010", fi.imem_addr); end
        ack_with(32'h10000003);
        exp_i = sb.pop_front();
        n_cmp++; if (fi.instr !== exp_i) begin n_err++; $display("FAIL br_instr: got %h want %h", fi.instr, exp_i); end
        accept(1'b1, 1'b0, 32'h00000043, exp_i);
        n_cmp++; if (fi.imem_addr !== 32'h40 || fi.imem_addr !== exp_pc) begin n_err++; $display("FAIL br_target: got %h want 00000040", fi.imem_addr); end
        ack_with(32'h08000100);
        exp_i = sb.pop_front();
        n_cmp++; if (fi.instr !== exp_i) begin n_err++; $display("FAIL jmp_instr: got %h want %h", fi.instr, exp_i); end
        accept(1'b1, 1'b1, 32'h00000043, exp_i);
        n_cmp++; if (fi.imem_addr !== 32'h400 || fi.imem_addr !== exp_pc) begin n_err++; $display("FAIL jmp_target: got %h want 00000400", fi.imem_addr); end
        ack_with(32'h00000000);
        exp_i = sb.pop_front();
        accept(1'b1, 1'b0, 32'hFFFFFFFF, exp_i);
        n_cmp++; if (fi.imem_addr !== 32'hFFFFFFFC) begin n_err++; $display("FAIL wrap_pc: got %h want fffffffc", fi.imem_addr); end
        n_cmp++; if (fi.pcplus4 !== 32'd0) begin n_err++; $display("FAIL wrap_pcplus4: got %h want 0", fi.pcplus4); end
        ack_with(32'h00000000);
        exp_i = sb.pop_front();
        accept(1'b0, 1'b0, 32'd0, exp_i);
        n_cmp++; if (fi.imem_addr !== 32'd0 || exp_pc !== 32'd0) begin n_err++; $display("FAIL wrap_seq: got %h want 0", fi.imem_addr); end
        n_cmp++; if (fi.instr_count !== exp_cnt) begin n_err++; $display("FAIL redir_count: got %0d want %0d", fi.instr_count, exp_cnt); end
    endtask

    task automatic test_timeout();
        for (int i = 1; i < TMO; i++) tick();
        n_cmp++; if (fi.fetch_err !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", fi.fetch_err); end
        tick();
        n_cmp++; if (fi.fetch_err !== 1'b1) begin n_err++; $display("FAIL tmo_set: got %b want 1", fi.fetch_err); end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (fi.imem_req !== 1'b1 || fi.imem_addr !== exp_pc) begin n_err++; $display("FAIL tmo_req: got %b/%h want 1/%h", fi.imem_req, fi.imem_addr, exp_pc); end
        ack_with(32'h3C01ABCD);
        exp_i = sb.pop_front();
        n_cmp++; if (fi.instr_valid !== 1'b1 || fi.instr !== exp_i) begin n_err++; $display("FAIL tmo_late_ack: got %b/%h want 1/%h", fi.instr_valid, fi.instr, exp_i); end
        accept(1'b0, 1'b0, 32'd0, exp_i);
        n_cmp++; if (fi.fetch_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", fi.fetch_err); end
    endtask

    task automatic test_reset_midfetch();
        tick();
        tick();
        reset = 1'b1;
        fi.imem_ack = 1'b1;
        fi.imem_rdata = 32'hCAFEBABE;
        #1;
        n_cmp++; if (fi.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", fi.imem_req); end
        tick();
        reset = 1'b0;
        fi.imem_ack = 1'b0;
        fi.imem_rdata = 32'd0;
        exp_pc = RPC;
        exp_cnt = 32'd0;
        #1;
        n_cmp++; if (fi.imem_addr !== RPC || fi.imem_req !== 1'b1) begin n_err++; $display("FAIL rst_addr: got %h/%b want %h/1", fi.imem_addr, fi.imem_req, RPC); end
        n_cmp++; if (fi.instr_valid !== 1'b0 || fi.instr !== 32'd0) begin n_err++; $display("FAIL rst_instr: got %b/%h want 0/0", fi.instr_valid, fi.instr); end
        n_cmp++; if (fi.instr_count !== 32'd0 || fi.fetch_err !== 1'b0) begin n_err++; $display("FAIL rst_cnt_err: got %0d/%b want 0/0", fi.instr_count, fi.fetch_err); end
        ack_with(32'h8C090004);
        exp_i = sb.pop_front();
        n_cmp++; if (fi.instr !== exp_i || fi.op !== 6'h23) begin n_err++; $display("FAIL rst_refetch: got %h want %h", fi.instr, exp_i); end
        accept(1'b0, 1'b0, 32'd0, exp_i);
        n_cmp++; if (fi.instr_count !== exp_cnt || fi.imem_addr !== exp_pc) begin n_err++; $display("FAIL rst_after: got %0d/%h want %0d/%h", fi.instr_count, fi.imem_addr, exp_cnt, exp_pc); end
        n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL sb_drain: got %0d want 0", sb.size()); end
    endtask

    initial begin
        fi.imem_ack = 1'b0;
        fi.imem_rdata = 32'd0;
        fi.instr_ready = 1'b0;
        fi.pcsrc = 1'b0;
        fi.jump = 1'b0;
        fi.pcbranch = 32'd0;
        exp_pc = RPC;
        exp_cnt = 32'd0;
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_hold_stall();
        test_redirect();
        test_timeout();
        test_reset_midfetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
